// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared opcodes, FSM states and counter type for the AXI-to-memory-model bridge
package axi_mem_pkg;

  localparam logic OPC_RD = 1'b0;
  localparam logic OPC_WR = 1'b1;

  localparam int DEF_LEN_BITS = 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_DATA,
    ST_WR_RESP
  } state_t;

  typedef logic [DEF_LEN_BITS-1:0] beat_cnt_t;

endpackage

// File: rtl/axi_mem_dpi_bridge_if.sv
// rtl/axi_mem_dpi_bridge_if.sv - AXI4 slave channels plus memory-model request/data signals
interface axi_mem_dpi_bridge_if #(
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 4
);

  logic                   ar_valid;
  logic                   ar_ready;
  logic [ADDR_BITS-1:0]   ar_addr;
  logic [LEN_BITS-1:0]    ar_len;
  logic [ID_BITS-1:0]     ar_id;

  logic                   r_valid;
  logic                   r_ready;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_last;
  logic [ID_BITS-1:0]     r_id;

  logic                   aw_valid;
  logic                   aw_ready;
  logic [ADDR_BITS-1:0]   aw_addr;
  logic [LEN_BITS-1:0]    aw_len;
  logic [ID_BITS-1:0]     aw_id;

  logic                   w_valid;
  logic                   w_ready;
  logic [DATA_BITS-1:0]   w_data;
  logic [DATA_BITS/8-1:0] w_strb;
  logic                   w_last;

  logic                   b_valid;
  logic                   b_ready;
  logic [ID_BITS-1:0]     b_id;

  logic                   mem_req_valid;
  logic                   mem_req_opcode;
  logic [LEN_BITS-1:0]    mem_req_len;
  logic [ADDR_BITS-1:0]   mem_req_addr;
  logic                   mem_wr_valid;
  logic [DATA_BITS-1:0]   mem_wr_bits;
  logic                   mem_rd_valid;
  logic [DATA_BITS-1:0]   mem_rd_bits;
  logic                   mem_rd_ready;

  // Bridge side: AXI slave toward the accelerator, requester toward the model.
  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_id,
    output ar_ready,
    output r_valid, r_data, r_last, r_id,
    input  r_ready,
    input  aw_valid, aw_addr, aw_len, aw_id,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id,
    input  b_ready,
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_wr_valid, mem_wr_bits,
    input  mem_rd_valid, mem_rd_bits,
    output mem_rd_ready
  );

  modport master (
    output ar_valid, ar_addr, ar_len, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_last, r_id,
    output r_ready,
    output aw_valid, aw_addr, aw_len, aw_id,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id,
    output b_ready,
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_wr_valid, mem_wr_bits,
    output mem_rd_valid, mem_rd_bits,
    input  mem_rd_ready
  );

endinterface

// File: rtl/axi_mem_rr_arb.sv
// rtl/axi_mem_rr_arb.sv - two-requester round-robin arbiter between the AR and AW channels
module axi_mem_rr_arb (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic req_r,
  input  logic req_w,
  input  logic accept,
  output logic grant_r,
  output logic grant_w
);

  // 1 = write channel won the most recent accepted grant
  logic last_grant;

  always_comb begin
    grant_r = 1'b0;
    grant_w = 1'b0;
    if (enable) begin
      if (req_r && req_w) begin
        grant_r = last_grant;
        grant_w = !last_grant;
      end else begin
        grant_r = req_r;
        grant_w = req_w;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_w;
    end
  end

endmodule

// File: rtl/axi_mem_dpi_bridge.sv
// rtl/axi_mem_dpi_bridge.sv - single-outstanding AXI4 burst to memory-model request bridge
module axi_mem_dpi_bridge
  import axi_mem_pkg::*;
#(
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_mem_dpi_bridge_if.slave  bus,
  output logic                 err
);

  state_t               state;
  logic                 opc_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ID_BITS-1:0]   id_q;
  logic [LEN_BITS-1:0]  beat_cnt;
  logic                 req_valid_q;
  logic                 rd_active;
  logic                 wr_active;
  logic                 b_valid_q;

  logic grant_r;
  logic grant_w;
  logic accept;
  logic last_beat;

  assign last_beat = (beat_cnt == len_q);
  assign accept    = (bus.ar_valid && grant_r) || (bus.aw_valid && grant_w);

  axi_mem_rr_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .enable  (state == ST_IDLE),
    .req_r   (bus.ar_valid),
    .req_w   (bus.aw_valid),
    .accept  (accept),
    .grant_r (grant_r),
    .grant_w (grant_w)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INIT;
      opc_q       <= OPC_RD;
      len_q       <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      beat_cnt    <= '0;
      req_valid_q <= 1'b0;
      rd_active   <= 1'b0;
      wr_active   <= 1'b0;
      b_valid_q   <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Model beats arriving when no read is in flight are dropped and flagged.
      if (bus.mem_rd_valid && state != ST_RD_DATA) begin
        err <= 1'b1;
      end
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (grant_r) begin
            opc_q       <= OPC_RD;
            len_q       <= bus.ar_len;
            addr_q      <= bus.ar_addr;
            id_q        <= bus.ar_id;
            req_valid_q <= 1'b1;
            state       <= ST_RD_REQ;
          end else if (grant_w) begin
            opc_q       <= OPC_WR;
            len_q       <= bus.aw_len;
            addr_q      <= bus.aw_addr;
            id_q        <= bus.aw_id;
            req_valid_q <= 1'b1;
            state       <= ST_WR_REQ;
          end
        end
        ST_RD_REQ: begin
          req_valid_q <= 1'b0;
          rd_active   <= 1'b1;
          state       <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (bus.mem_rd_valid && bus.r_ready) begin
            if (last_beat) begin
              beat_cnt  <= '0;
              rd_active <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_WR_REQ: begin
          req_valid_q <= 1'b0;
          wr_active   <= 1'b1;
          state       <= ST_WR_DATA;
        end
        ST_WR_DATA: begin
          if (bus.w_valid) begin
            // Beat count, not w_last, decides where the burst ends.
            if ((bus.w_last != last_beat) || !(&bus.w_strb)) begin
              err <= 1'b1;
            end
            if (last_beat) begin
              beat_cnt  <= '0;
              wr_active <= 1'b0;
              b_valid_q <= 1'b1;
              state     <= ST_WR_RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_WR_RESP: begin
          if (bus.b_ready) begin
            b_valid_q <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.ar_ready       = grant_r;
  assign bus.aw_ready       = grant_w;

  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_req_opcode = opc_q;
  assign bus.mem_req_len    = len_q;
  assign bus.mem_req_addr   = addr_q;

  assign bus.r_valid        = rd_active && bus.mem_rd_valid;
  assign bus.r_data         = rd_active ? bus.mem_rd_bits : '0;
  assign bus.r_last         = rd_active && last_beat;
  assign bus.r_id           = rd_active ? id_q : '0;
  assign bus.mem_rd_ready   = rd_active && bus.r_ready;

  assign bus.w_ready        = wr_active;
  assign bus.mem_wr_valid   = wr_active && bus.w_valid;
  assign bus.mem_wr_bits    = wr_active ? bus.w_data : '0;

  assign bus.b_valid        = b_valid_q;
  assign bus.b_id           = b_valid_q ? id_q : '0;

endmodule

// File: tb/tb_axi_mem_dpi_bridge.sv
// tb/tb_axi_mem_dpi_bridge.sv - directed self-checking bench for axi_mem_dpi_bridge
module tb_axi_mem_dpi_bridge;

  logic clock;
  logic reset;
  logic err;

  int n_pass;
  int n_total;
  int req_count;
  logic opc_log[$];

  axi_mem_dpi_bridge_if bus ();

  axi_mem_dpi_bridge dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.mem_req_valid === 1'b1) begin
      req_count++;
      opc_log.push_back(bus.mem_req_opcode);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic start_write(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
    bus.aw_len   = len;
    bus.aw_id    = id;
    #1;
    step();
    bus.aw_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ar_valid = 1'b1;
    step();
    #1;
    n_total++; if (bus.ar_ready !== 1'b0) $display("FAIL rst_ar_ready: got %0b expected 0", bus.ar_ready); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %0b expected 0", err); else n_pass++;
    n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rst_mem_req_valid: got %0b expected 0", bus.mem_req_valid); else n_pass++;
    n_total++; if ({bus.b_valid, bus.w_ready, bus.r_valid, bus.mem_rd_ready, bus.aw_ready, bus.mem_wr_valid} !== 6'b0)
      $display("FAIL rst_outputs: got %b expected 000000", {bus.b_valid, bus.w_ready, bus.r_valid, bus.mem_rd_ready, bus.aw_ready, bus.mem_wr_valid});
    else n_pass++;
    step();
    #1;
    reset = 1'b0;
    #1;
    n_total++; if (bus.ar_ready !== 1'b0) $display("FAIL init_ar_ready: got %0b expected 0", bus.ar_ready); else n_pass++;
    step();
    n_total++; if (bus.ar_ready !== 1'b1) $display("FAIL idle_ar_ready: got %0b expected 1", bus.ar_ready); else n_pass++;
    bus.ar_valid = 1'b0;
    #1;
  endtask

  task automatic test_read_burst();
    logic [63:0] d;
    int start_cnt;
    start_cnt = req_count;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 64'h1000;
    bus.ar_len   = 8'd3;
    bus.ar_id    = 4'd5;
    #1;
    n_total++; if (bus.ar_ready !== 1'b1) $display("FAIL rd_ar_ready: got %0b expected 1", bus.ar_ready); else n_pass++;
    step();
    bus.ar_valid = 1'b0;
    #1;
    n_total++; if ({bus.mem_req_valid, bus.mem_req_opcode, bus.mem_req_len} !== {1'b1, 1'b0, 8'd3})
      $display("FAIL rd_req: got v=%0b op=%0b len=%0d expected v=1 op=0 len=3", bus.mem_req_valid, bus.mem_req_opcode, bus.mem_req_len);
    else n_pass++;
    n_total++; if (bus.mem_req_addr !== 64'h1000) $display("FAIL rd_req_addr: got %0h expected 1000", bus.mem_req_addr); else n_pass++;
    step();
    n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rd_req_pulse: got %0b expected 0", bus.mem_req_valid); else n_pass++;
    bus.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 64'h0123_4567_89AB_CD00 + 64'(i);
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_bits  = d;
      #1;
      n_total++; if ({bus.r_valid, bus.mem_rd_ready, bus.r_last} !== {1'b1, 1'b1, (i == 3)})
        $display("FAIL rd_beat%0d_flags: got v=%0b rdy=%0b last=%0b expected v=1 rdy=1 last=%0b", i, bus.r_valid, bus.mem_rd_ready, bus.r_last, (i == 3));
      else n_pass++;
      n_total++; if ({bus.r_data, bus.r_id} !== {d, 4'd5})
        $display("FAIL rd_beat%0d_data: got %0h id %0d expected %0h id 5", i, bus.r_data, bus.r_id, d);
      else n_pass++;
      step();
    end
    bus.mem_rd_valid = 1'b0;
    bus.r_ready = 1'b0;
    bus.ar_valid = 1'b1;
    #1;
    n_total++; if (bus.ar_ready !== 1'b1) $display("FAIL rd_back_idle: got %0b expected 1", bus.ar_ready); else n_pass++;
    bus.ar_valid = 1'b0;
    #1;
    n_total++; if (req_count - start_cnt !== 1) $display("FAIL rd_req_count: got %0d expected 1", req_count - start_cnt); else n_pass++;
  endtask

  task automatic test_write_single();
    bus.aw_valid = 1'b1;
    bus.aw_addr  = 64'h2000;
    bus.aw_len   = 8'd0;
    bus.aw_id    = 4'd9;
    #1;
    n_total++; if (bus.aw_ready !== 1'b1) $display("FAIL wr_aw_ready: got %0b expected 1", bus.aw_ready); else n_pass++;
    step();
    bus.aw_valid = 1'b0;
    n_total++; if ({bus.mem_req_valid, bus.mem_req_opcode, bus.mem_req_len, bus.mem_req_addr} !== {1'b1, 1'b1, 8'd0, 64'h2000})
      $display("FAIL wr_req: got v=%0b op=%0b len=%0d addr=%0h expected v=1 op=1 len=0 addr=2000", bus.mem_req_valid, bus.mem_req_opcode, bus.mem_req_len, bus.mem_req_addr);
    else n_pass++;
    step();
    bus.w_valid = 1'b1;
    bus.w_data  = 64'hDEAD_BEEF;
    bus.w_strb  = 8'hFF;
    bus.w_last  = 1'b1;
    #1;
    n_total++; if ({bus.w_ready, bus.mem_wr_valid} !== 2'b11) $display("FAIL wr_beat_valid: got %b expected 11", {bus.w_ready, bus.mem_wr_valid}); else n_pass++;
    n_total++; if (bus.mem_wr_bits !== 64'hDEAD_BEEF) $display("FAIL wr_beat_bits: got %0h expected deadbeef", bus.mem_wr_bits); else n_pass++;
    step();
    bus.w_valid = 1'b0;
    #1;
    n_total++; if (bus.mem_wr_valid !== 1'b0) $display("FAIL wr_single_beat: got %0b expected 0", bus.mem_wr_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if ({bus.b_valid, bus.b_id} !== {1'b1, 4'd9}) $display("FAIL wr_b_hold%0d: got v=%0b id=%0d expected v=1 id=9", i, bus.b_valid, bus.b_id); else n_pass++;
      step();
    end
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    #1;
    n_total++; if (bus.b_valid !== 1'b0) $display("FAIL wr_b_release: got %0b expected 0", bus.b_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL wr_no_err: got %0b expected 0", err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic exp_r;
    opc_log.delete();
    bus.ar_addr = 64'h5000; bus.ar_len = 8'd0; bus.ar_id = 4'd1;
    bus.aw_addr = 64'h6000; bus.aw_len = 8'd0; bus.aw_id = 4'd7;
    for (int k = 0; k < 3; k++) begin
      exp_r = (k != 1);
      bus.ar_valid = 1'b1;
      bus.aw_valid = 1'b1;
      #1;
      n_total++; if ({bus.ar_ready, bus.aw_ready} !== {exp_r, !exp_r})
        $display("FAIL b2b_grant%0d: got ar=%0b aw=%0b expected ar=%0b aw=%0b", k, bus.ar_ready, bus.aw_ready, exp_r, !exp_r);
      else n_pass++;
      step();
      if (exp_r) bus.ar_valid = 1'b0; else bus.aw_valid = 1'b0;
      step();
      if (exp_r) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_bits  = 64'h77;
        bus.r_ready      = 1'b1;
        step();
        bus.mem_rd_valid = 1'b0;
        bus.r_ready      = 1'b0;
      end else begin
        bus.w_valid = 1'b1; bus.w_data = 64'h88; bus.w_strb = 8'hFF; bus.w_last = 1'b1;
        step();
        bus.w_valid = 1'b0;
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
      end
    end
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    step();
    n_total++; if (opc_log.size() !== 3) $display("FAIL b2b_req_count: got %0d expected 3", opc_log.size()); else n_pass++;
    if (opc_log.size() == 3) begin
      n_total++; if ({opc_log[0], opc_log[1], opc_log[2]} !== 3'b010)
        $display("FAIL b2b_opcodes: got %b expected 010", {opc_log[0], opc_log[1], opc_log[2]});
      else n_pass++;
    end
  endtask

  task automatic test_max_len();
    start_write(64'h7000, 8'd255, 4'd6);
    bus.w_strb = 8'hFF;
    for (int i = 0; i < 256; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = 64'(i);
      bus.w_last  = (i == 255);
      #1;
      if (i == 0 || i == 255) begin
        n_total++; if ({bus.w_ready, bus.b_valid} !== 2'b10) $display("FAIL maxlen_beat%0d: got rdy,b=%b expected 10", i, {bus.w_ready, bus.b_valid}); else n_pass++;
      end
      step();
    end
    bus.w_valid = 1'b0;
    #1;
    n_total++; if ({bus.w_ready, bus.b_valid} !== 2'b01) $display("FAIL maxlen_done: got rdy,b=%b expected 01", {bus.w_ready, bus.b_valid}); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL maxlen_err: got %0b expected 0", err); else n_pass++;
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
  endtask

  task automatic test_write_errors();
    start_write(64'h4000, 8'd2, 4'd4);
    bus.w_strb = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = 64'h100 + 64'(i);
      bus.w_last  = (i == 1);
      step();
      if (i == 0) begin
        n_total++; if (err !== 1'b0) $display("FAIL werr_beat0: got %0b expected 0", err); else n_pass++;
      end else if (i == 1) begin
        n_total++; if ({err, bus.w_ready, bus.b_valid} !== 3'b110) $display("FAIL werr_beat1: got err,rdy,b=%b expected 110", {err, bus.w_ready, bus.b_valid}); else n_pass++;
      end
    end
    bus.w_valid = 1'b0;
    #1;
    n_total++; if ({bus.b_valid, bus.b_id, err} !== {1'b1, 4'd4, 1'b1})
      $display("FAIL werr_complete: got b=%0b id=%0d err=%0b expected b=1 id=4 err=1", bus.b_valid, bus.b_id, err);
    else n_pass++;
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    step();
    n_total++; if (err !== 1'b1) $display("FAIL werr_sticky: got %0b expected 1", err); else n_pass++;
    do_reset();
    n_total++; if (err !== 1'b0) $display("FAIL werr_cleared: got %0b expected 0", err); else n_pass++;
    start_write(64'h4100, 8'd0, 4'd2);
    bus.w_valid = 1'b1; bus.w_data = 64'h55; bus.w_strb = 8'h0F; bus.w_last = 1'b1;
    step();
    bus.w_valid = 1'b0;
    bus.w_strb  = 8'hFF;
    #1;
    n_total++; if ({err, bus.b_valid} !== 2'b11) $display("FAIL strb_err: got err,b=%b expected 11", {err, bus.b_valid}); else n_pass++;
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
  endtask

  task automatic test_stray_read();
    do_reset();
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_bits  = 64'h99;
    bus.r_ready      = 1'b1;
    #1;
    n_total++; if ({bus.mem_rd_ready, bus.r_valid} !== 2'b00) $display("FAIL stray_drop: got rdy,v=%b expected 00", {bus.mem_rd_ready, bus.r_valid}); else n_pass++;
    step();
    bus.mem_rd_valid = 1'b0;
    bus.r_ready      = 1'b0;
    #1;
    n_total++; if (err !== 1'b1) $display("FAIL stray_err: got %0b expected 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int beats;
    logic [63:0] d;
    do_reset();
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 64'h3000;
    bus.ar_len   = 8'd7;
    bus.ar_id    = 4'd3;
    #1;
    step();
    bus.ar_valid = 1'b0;
    step();
    beats = 0;
    for (int cyc = 0; cyc < 30 && beats < 5; cyc++) begin
      d = 64'hBEEF_0000 + 64'(beats);
      bus.r_ready      = (cyc % 2 == 0);
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_bits  = d;
      #1;
      n_total++; if ({bus.r_valid, bus.r_data, bus.r_last, bus.mem_rd_ready} !== {1'b1, d, 1'b0, bus.r_ready})
        $display("FAIL mid_cyc%0d: got v=%0b data=%0h last=%0b rdy=%0b expected v=1 data=%0h last=0 rdy=%0b",
                 cyc, bus.r_valid, bus.r_data, bus.r_last, bus.mem_rd_ready, d, bus.r_ready);
      else n_pass++;
      if (bus.r_ready) beats++;
      step();
    end
    n_total++; if (beats !== 5) $display("FAIL mid_beats: got %0d expected 5", beats); else n_pass++;
    reset = 1'b1;
    bus.mem_rd_valid = 1'b0;
    bus.r_ready = 1'b0;
    bus.ar_valid = 1'b1;
    step();
    n_total++; if ({bus.r_valid, bus.mem_rd_ready, bus.mem_req_valid, bus.ar_ready, err} !== 5'b0)
      $display("FAIL mid_reset_outputs: got %b expected 00000", {bus.r_valid, bus.mem_rd_ready, bus.mem_req_valid, bus.ar_ready, err});
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (bus.ar_ready !== 1'b0) $display("FAIL mid_init: got %0b expected 0", bus.ar_ready); else n_pass++;
    step();
    n_total++; if ({bus.ar_ready, err} !== 2'b10) $display("FAIL mid_idle: got rdy,err=%b expected 10", {bus.ar_ready, err}); else n_pass++;
    bus.ar_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    req_count = 0;
    reset = 1'b1;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_id = '0;
    bus.r_ready  = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_id = '0;
    bus.w_valid  = 1'b0; bus.w_data = '0; bus.w_strb = 8'hFF; bus.w_last = 1'b0;
    bus.b_ready  = 1'b0;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_bits = '0;
    test_reset();
    test_read_burst();
    test_write_single();
    test_back_to_back();
    test_max_len();
    test_write_errors();
    test_stray_read();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
